// File: rtl/coefficient_sequencer.sv
// rtl/coefficient_sequencer.sv - zigzag coefficients to JPEG (run, size, amplitude) symbols
// Optional COEF_SEQ_STATS_EN adds completed-block and transferred-symbol counters.
module coefficient_sequencer #(
  parameter int NUM_COMPONENTS = 3,
  parameter int COMP_W         = 2
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_dc_clear,
  input  logic              i_coef_valid,
  output logic              o_coef_ready,
  input  logic [15:0]       i_coefficient,
  input  logic [COMP_W-1:0] i_comp_id,
  output logic              o_sym_valid,
  input  logic              i_sym_ready,
  output logic              o_sym_is_dc,
  output logic              o_sym_last,
  output logic [3:0]        o_sym_run,
  output logic [3:0]        o_sym_size,
  output logic [15:0]       o_sym_bits
`ifdef COEF_SEQ_STATS_EN
  ,
  output logic [31:0]       o_stat_blocks,
  output logic [31:0]       o_stat_symbols
`endif
);

  typedef enum logic [1:0] {S_ACCEPT, S_EMIT_ZRL, S_EMIT_SYM, S_EMIT_EOB} state_t;
  state_t r_state, w_next;

  logic [5:0]  r_index, r_run;
  logic [1:0]  r_pending;
  logic [15:0] r_hold;
  logic [3:0]  r_hold_run;
  logic        r_hold_last;
  logic [15:0] r_pred [NUM_COMPONENTS];

  logic        r_sym_valid, r_sym_is_dc, r_sym_last;
  logic [3:0]  r_sym_run, r_sym_size;
  logic [15:0] r_sym_bits;

  logic        w_out_free, w_xfer, w_accept, w_is_dc, w_zero, w_idx63, w_comp_ok;
  logic [15:0] w_pred_sel, w_diff, w_enc_in, w_mag, w_raw, w_mask, w_enc_bits;
  logic [4:0]  w_size_full;
  logic [3:0]  w_enc_size;

  assign w_out_free   = !r_sym_valid || i_sym_ready;
  assign w_xfer       = r_sym_valid && i_sym_ready;
  assign o_coef_ready = (r_state == S_ACCEPT) && w_out_free && !i_reset;
  assign w_accept     = i_coef_valid && o_coef_ready;
  assign w_is_dc      = (r_index == 6'd0);
  assign w_zero       = (i_coefficient == 16'd0);
  assign w_idx63      = (r_index == 6'd63);
  assign w_comp_ok    = (32'(i_comp_id) < NUM_COMPONENTS);

  // A coincident dc_clear or an unknown component both predict from zero.
  assign w_pred_sel = (i_dc_clear || !w_comp_ok) ? 16'd0 : r_pred[i_comp_id];
  assign w_diff     = i_coefficient - w_pred_sel;
  assign w_enc_in   = (r_state == S_ACCEPT) ? (w_is_dc ? w_diff : i_coefficient) : r_hold;

  // Magnitude category and ones-complement amplitude bits for negatives.
  always_comb begin
    w_mag       = w_enc_in[15] ? (~w_enc_in + 16'd1) : w_enc_in;
    w_size_full = 5'd0;
    for (int b = 0; b < 16; b++) begin
      if (w_mag[b]) w_size_full = 5'(b + 1);
    end
    w_enc_size = (w_size_full > 5'd15) ? 4'd15 : w_size_full[3:0];
    w_raw      = w_enc_in[15] ? (w_enc_in - 16'd1) : w_enc_in;
    w_mask     = (16'd1 << w_enc_size) - 16'd1;
    w_enc_bits = w_raw & w_mask;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= S_ACCEPT;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_ACCEPT: begin
        if (w_accept && !w_is_dc && !w_zero && (r_run >= 6'd16)) w_next = S_EMIT_ZRL;
        else if (w_accept && !w_is_dc && w_zero && w_idx63)      w_next = S_EMIT_EOB;
      end
      S_EMIT_ZRL: if (w_xfer && (r_pending == 2'd1)) w_next = S_EMIT_SYM;
      S_EMIT_SYM: if (w_xfer) w_next = S_ACCEPT;
      S_EMIT_EOB: if (w_xfer) w_next = S_ACCEPT;
      default:    w_next = S_ACCEPT;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int k = 0; k < NUM_COMPONENTS; k++) r_pred[k] <= 16'd0;
    end else begin
      if (i_dc_clear) begin
        for (int k = 0; k < NUM_COMPONENTS; k++) r_pred[k] <= 16'd0;
      end
      if (w_accept && w_is_dc && w_comp_ok) r_pred[i_comp_id] <= i_coefficient;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_index     <= 6'd0;
      r_run       <= 6'd0;
      r_pending   <= 2'd0;
      r_hold      <= 16'd0;
      r_hold_run  <= 4'd0;
      r_hold_last <= 1'b0;
      r_sym_valid <= 1'b0;
      r_sym_is_dc <= 1'b0;
      r_sym_last  <= 1'b0;
      r_sym_run   <= 4'd0;
      r_sym_size  <= 4'd0;
      r_sym_bits  <= 16'd0;
    end else begin
      if (w_xfer) r_sym_valid <= 1'b0;
      case (r_state)
        S_ACCEPT: if (w_accept) begin
          if (w_is_dc) begin
            r_sym_valid <= 1'b1;
            r_sym_is_dc <= 1'b1;
            r_sym_last  <= 1'b0;
            r_sym_run   <= 4'd0;
            r_sym_size  <= w_enc_size;
            r_sym_bits  <= w_enc_bits;
            r_index     <= 6'd1;
            r_run       <= 6'd0;
          end else if (w_zero) begin
            r_index <= r_index + 6'd1;
            if (w_idx63) begin
              // Trailing zeros collapse into a single EOB, never ZRLs.
              r_sym_valid <= 1'b1;
              r_sym_is_dc <= 1'b0;
              r_sym_last  <= 1'b1;
              r_sym_run   <= 4'd0;
              r_sym_size  <= 4'd0;
              r_sym_bits  <= 16'd0;
              r_run       <= 6'd0;
            end else begin
              r_run <= r_run + 6'd1;
            end
          end else begin
            r_index     <= r_index + 6'd1;
            r_run       <= 6'd0;
            r_sym_valid <= 1'b1;
            r_sym_is_dc <= 1'b0;
            if (r_run < 6'd16) begin
              r_sym_last <= w_idx63;
              r_sym_run  <= r_run[3:0];
              r_sym_size <= w_enc_size;
              r_sym_bits <= w_enc_bits;
            end else begin
              // Park the coefficient; the first ZRL goes out immediately.
              r_hold      <= i_coefficient;
              r_hold_run  <= r_run[3:0];
              r_hold_last <= w_idx63;
              r_pending   <= r_run[5:4];
              r_sym_last  <= 1'b0;
              r_sym_run   <= 4'd15;
              r_sym_size  <= 4'd0;
              r_sym_bits  <= 16'd0;
            end
          end
        end
        S_EMIT_ZRL: if (w_xfer) begin
          r_pending   <= r_pending - 2'd1;
          r_sym_valid <= 1'b1;
          r_sym_is_dc <= 1'b0;
          if (r_pending == 2'd1) begin
            r_sym_last <= r_hold_last;
            r_sym_run  <= r_hold_run;
            r_sym_size <= w_enc_size;
            r_sym_bits <= w_enc_bits;
          end else begin
            r_sym_last <= 1'b0;
            r_sym_run  <= 4'd15;
            r_sym_size <= 4'd0;
            r_sym_bits <= 16'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_sym_valid = r_sym_valid;
  assign o_sym_is_dc = r_sym_is_dc;
  assign o_sym_last  = r_sym_last;
  assign o_sym_run   = r_sym_run;
  assign o_sym_size  = r_sym_size;
  assign o_sym_bits  = r_sym_bits;

`ifdef COEF_SEQ_STATS_EN
  logic [31:0] r_stat_blocks, r_stat_symbols;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_stat_blocks  <= 32'd0;
      r_stat_symbols <= 32'd0;
    end else if (w_xfer) begin
      r_stat_symbols <= r_stat_symbols + 32'd1;
      if (r_sym_last) r_stat_blocks <= r_stat_blocks + 32'd1;
    end
  end

  assign o_stat_blocks  = r_stat_blocks;
  assign o_stat_symbols = r_stat_symbols;
`endif

endmodule
